// File: rtl/march_c_controller_pkg.sv
// Shared definitions for the March C- BIST sequencer: FSM states and element table.
package march_c_controller_pkg;

    localparam int unsigned NUM_ELEM = 6;
    localparam int unsigned ELEM_W   = 3;
    localparam int unsigned ERR_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SWEEP = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // One March element: sweep direction, optional read with expected background,
    // optional write with written background.
    typedef struct packed {
        logic up;
        logic has_rd;
        logic rd_bg;
        logic has_wr;
        logic wr_bg;
    } elem_t;

    // M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 dn(r0,w1), M4 dn(r1,w0), M5 dn(r0)
    localparam elem_t ELEM_TABLE [NUM_ELEM] = '{
        '{up: 1'b1, has_rd: 1'b0, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b0},
        '{up: 1'b1, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b1},
        '{up: 1'b1, has_rd: 1'b1, rd_bg: 1'b1, has_wr: 1'b1, wr_bg: 1'b0},
        '{up: 1'b0, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b1},
        '{up: 1'b0, has_rd: 1'b1, rd_bg: 1'b1, has_wr: 1'b1, wr_bg: 1'b0},
        '{up: 1'b0, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b0, wr_bg: 1'b0}
    };

endpackage

// File: rtl/march_c_controller.sv
// March C- BIST sequencer: drives an external address generator and a dual-port RAM,
// reading at address a and writing back at a one cycle later.
module march_c_controller
    import march_c_controller_pkg::*;
#(
    parameter int unsigned AD_W = 4,
    parameter int unsigned DW   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                ag_reset,
    output logic                ag_preset,
    output logic                ag_en,
    output logic                ag_up_down,
    input  logic [AD_W-1:0]     ag_address,
    input  logic                ag_carry,
    output logic                mem_re,
    output logic [AD_W-1:0]     mem_raddr,
    input  logic [DW-1:0]       mem_rdata,
    output logic                mem_we,
    output logic [AD_W-1:0]     mem_waddr,
    output logic [DW-1:0]       mem_wdata,
    output logic [AD_W-1:0]     fail_addr,
    output logic [ELEM_W-1:0]   fail_elem,
    output logic [ERR_W-1:0]    err_count
);

    state_e              state_q, state_d;
    logic [ELEM_W-1:0]   e_q, e_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [AD_W-1:0]     fail_addr_q, fail_addr_d;
    logic [ELEM_W-1:0]   fail_elem_q, fail_elem_d;
    logic                pass_q, pass_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ag_reset_q, ag_reset_d;
    logic                ag_preset_q, ag_preset_d;
    logic                ag_en_q, ag_en_d;
    logic                ag_up_down_q, ag_up_down_d;
    logic                mem_re_q, mem_re_d;
    logic                mem_we_q, mem_we_d;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
    logic [AD_W-1:0]     a_q, a_d;
    logic                cmp_v_q, cmp_v_d;
    logic [DW-1:0]       exp_q, exp_d;
    logic                mismatch_c;

    // Sequencing, element advance and mismatch bookkeeping
    always_comb begin
        state_d     = state_q;
        e_d         = e_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        pass_d      = pass_q;
        mismatch_c  = cmp_v_q && (mem_rdata != exp_q);

        if (mismatch_c) begin
            if (err_q != '1) begin
                err_d = err_q + ERR_W'(1);
            end
            if (err_q == '0) begin
                fail_addr_d = a_q;
                fail_elem_d = e_q;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_SETUP;
                    e_d         = '0;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                    pass_d      = 1'b0;
                end
            end
            ST_SETUP: state_d = ST_SWEEP;
            ST_SWEEP: begin
                if (ag_carry) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (e_q == ELEM_W'(NUM_ELEM - 1)) begin
                    state_d = ST_DONE;
                    // Include the final compare of this cycle in the verdict
                    pass_d  = (err_d == '0);
                end else begin
                    e_d     = e_q + ELEM_W'(1);
                    state_d = ST_SETUP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of registered outputs and the read-to-write pipe stage
    always_comb begin
        busy_d       = (state_d == ST_SETUP) || (state_d == ST_SWEEP) || (state_d == ST_DRAIN);
        done_d       = (state_d == ST_DONE);
        ag_reset_d   = (state_d == ST_IDLE) || (state_d == ST_DONE) ||
                       ((state_d == ST_SETUP) && ELEM_TABLE[e_d].up);
        ag_preset_d  = (state_d == ST_SETUP) && !ELEM_TABLE[e_d].up;
        ag_en_d      = (state_d == ST_SWEEP);
        ag_up_down_d = ELEM_TABLE[e_d].up;
        mem_re_d     = (state_d == ST_SWEEP) && ELEM_TABLE[e_d].has_rd;

        mem_we_d     = (state_q == ST_SWEEP) && ELEM_TABLE[e_q].has_wr;
        mem_wdata_d  = mem_we_d ? {DW{ELEM_TABLE[e_q].wr_bg}} : '0;
        a_d          = (state_q == ST_SWEEP) ? ag_address : a_q;
        cmp_v_d      = (state_q == ST_SWEEP) && ELEM_TABLE[e_q].has_rd;
        exp_d        = {DW{ELEM_TABLE[e_q].rd_bg}};
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            e_q          <= '0;
            err_q        <= '0;
            fail_addr_q  <= '0;
            fail_elem_q  <= '0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ag_reset_q   <= 1'b1;
            ag_preset_q  <= 1'b0;
            ag_en_q      <= 1'b0;
            ag_up_down_q <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            a_q          <= '0;
            cmp_v_q      <= 1'b0;
            exp_q        <= '0;
        end else begin
            state_q      <= state_d;
            e_q          <= e_d;
            err_q        <= err_d;
            fail_addr_q  <= fail_addr_d;
            fail_elem_q  <= fail_elem_d;
            pass_q       <= pass_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ag_reset_q   <= ag_reset_d;
            ag_preset_q  <= ag_preset_d;
            ag_en_q      <= ag_en_d;
            ag_up_down_q <= ag_up_down_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            a_q          <= a_d;
            cmp_v_q      <= cmp_v_d;
            exp_q        <= exp_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign ag_reset   = ag_reset_q;
    assign ag_preset  = ag_preset_q;
    assign ag_en      = ag_en_q;
    assign ag_up_down = ag_up_down_q;
    assign mem_re     = mem_re_q;
    assign mem_raddr  = ag_address;
    assign mem_we     = mem_we_q;
    assign mem_waddr  = a_q;
    assign mem_wdata  = mem_wdata_q;
    assign fail_addr  = fail_addr_q;
    assign fail_elem  = fail_elem_q;
    assign err_count  = err_q;

endmodule
